step_counter: RTL and testbench

// - Parametrised up/down counter with programmable step, modulo limit, wrap or saturate mode,

---
 rtl/step_counter_pkg.sv | 12 +
 rtl/step_counter_next.sv | 36 +++
 rtl/step_counter.sv | 87 ++++++++
 tb/tb_step_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared mode encodings and flag bundle for the step counter.
package step_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef struct packed {
        logic ovf;
        logic udf;
    } flags_t;

endpackage

// File: rtl/step_counter_next.sv
// step_counter_next: combinational next count and limit-crossing flags for one up or down step.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
)(
    input  logic [WIDTH-1:0]  cur,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    output logic [WIDTH-1:0]  nxt,
    output logic              ovf_n,
    output logic              udf_n
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] SPAN  = (WIDTH+1)'(MAX_VAL + 1);
    localparam bit             SAT   = (SATURATE == MODE_SAT);

    // One extra bit keeps the carry out of out+step visible.
    logic [WIDTH:0] c, s, sum, up_val, dn_val;

    always_comb begin
        c      = {1'b0, cur};
        s      = {{(WIDTH+1-STEP_W){1'b0}}, step};
        sum    = c + s;
        ovf_n  = dir && (sum > LIMIT);
        udf_n  = !dir && (s > c);
        up_val = (sum > LIMIT) ? (SAT ? LIMIT : sum - SPAN) : sum;
        dn_val = (s > c) ? (SAT ? '0 : SPAN - (s - c)) : c - s;
        nxt    = WIDTH'(dir ? up_val : dn_val);
    end

endmodule

// File: rtl/step_counter.sv
// step_counter: up/down counter with programmable step, modulo limit, wrap/saturate mode,
// clear/load priority, overflow/underflow pulses, sticky flags and threshold compare.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP,
    parameter int THRESH   = MAX_VAL
)(
    input  logic              aclk,
    input  logic              arstn,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  out,
    output logic              ovf,
    output logic              udf,
    output logic              ovf_sticky,
    output logic              udf_sticky,
    output logic              thresh_hit
);

    localparam logic [WIDTH-1:0] LIMIT    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

    // A step never exceeds the range, so one wrap correction is always enough.
    generate
        if ((2**STEP_W - 1 > MAX_VAL) || (THRESH > MAX_VAL) ||
            (longint'(MAX_VAL) >= (longint'(1) << WIDTH)) ||
            (SATURATE != MODE_WRAP && SATURATE != MODE_SAT)) begin : g_bad_params
            $error("step_counter: illegal parameter combination");
        end
    endgenerate

    flags_t         flags, sticky;
    logic [WIDTH-1:0] nxt;
    logic           ovf_n, udf_n;

    step_counter_next #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cur   (out),
        .step  (step),
        .dir   (inc),
        .nxt   (nxt),
        .ovf_n (ovf_n),
        .udf_n (udf_n)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            out    <= '0;
            flags  <= '0;
            sticky <= '0;
        end else if (clr) begin
            out    <= '0;
            flags  <= '0;
            sticky <= '0;
        end else if (load) begin
            out   <= (load_val > LIMIT) ? LIMIT : load_val;
            flags <= '0;
        end else if (inc ^ dec) begin
            out        <= nxt;
            flags.ovf  <= ovf_n;
            flags.udf  <= udf_n;
            sticky.ovf <= sticky.ovf | ovf_n;
            sticky.udf <= sticky.udf | udf_n;
        end else begin
            flags <= '0;
        end
    end

    assign ovf        = flags.ovf;
    assign udf        = flags.udf;
    assign ovf_sticky = sticky.ovf;
    assign udf_sticky = sticky.udf;
    assign thresh_hit = out >= THRESH_W;

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: four parameterisations driven by shared stimulus; directed spec scenarios
// plus a randomized run checked against an integer reference model.
module tb_step_counter;

    logic       aclk = 1'b0;
    logic       arstn = 1'b0;
    logic       clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [8:0] load_val = '0;
    logic [3:0] step = '0;

    logic [7:0] a_out, b_out, c_out;
    logic [8:0] d_out;
    logic a_ovf, a_udf, a_os, a_us, a_th;
    logic b_ovf, b_udf, b_os, b_us, b_th;
    logic c_ovf, c_udf, c_os, c_us, c_th;
    logic d_ovf, d_udf, d_os, d_us, d_th;

    int errors = 0;
    int checks = 0;

    // a: legacy default, b: MAX_VAL=9 wrap, c: 8-bit saturate, d: 9-bit MAX_VAL=200
    localparam int MX[4]  = '{255, 9, 255, 200};
    localparam int SAT[4] = '{0, 0, 1, 0};
    localparam int SM[4]  = '{15, 7, 15, 15};
    localparam int WM[4]  = '{255, 255, 255, 511};
    localparam int TH[4]  = '{255, 5, 255, 100};

    int m_out[4];
    bit m_ovf[4], m_udf[4], m_os[4], m_us[4];

    always #5 aclk = ~aclk;

    step_counter u_a (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val[7:0]),
        .inc(inc), .dec(dec), .step(step), .out(a_out), .ovf(a_ovf), .udf(a_udf),
        .ovf_sticky(a_os), .udf_sticky(a_us), .thresh_hit(a_th));

    step_counter #(.WIDTH(8), .STEP_W(3), .MAX_VAL(9), .THRESH(5)) u_b (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val[7:0]),
        .inc(inc), .dec(dec), .step(step[2:0]), .out(b_out), .ovf(b_ovf), .udf(b_udf),
        .ovf_sticky(b_os), .udf_sticky(b_us), .thresh_hit(b_th));

    step_counter #(.WIDTH(8), .SATURATE(1)) u_c (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val[7:0]),
        .inc(inc), .dec(dec), .step(step), .out(c_out), .ovf(c_ovf), .udf(c_udf),
        .ovf_sticky(c_os), .udf_sticky(c_us), .thresh_hit(c_th));

    step_counter #(.WIDTH(9), .MAX_VAL(200), .THRESH(100)) u_d (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .step(step), .out(d_out), .ovf(d_ovf), .udf(d_udf),
        .ovf_sticky(d_os), .udf_sticky(d_us), .thresh_hit(d_th));

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_os[i] = 0; m_us[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int s, lv, t;
            s  = int'(step) & SM[i];
            lv = int'(load_val) & WM[i];
            m_ovf[i] = 0;
            m_udf[i] = 0;
            if (clr) begin
                m_out[i] = 0; m_os[i] = 0; m_us[i] = 0;
            end else if (load) begin
                m_out[i] = (lv > MX[i]) ? MX[i] : lv;
            end else if (inc && !dec) begin
                t = m_out[i] + s;
                m_ovf[i] = t > MX[i];
                m_out[i] = !m_ovf[i] ? t : (SAT[i] != 0 ? MX[i] : t - (MX[i] + 1));
            end else if (dec && !inc) begin
                t = m_out[i] - s;
                m_udf[i] = t < 0;
                m_out[i] = !m_udf[i] ? t : (SAT[i] != 0 ? 0 : t + MX[i] + 1);
            end
            m_os[i] |= m_ovf[i];
            m_us[i] |= m_udf[i];
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input int lv, input logic i, input logic d, input int s);
        clr = c; load = l; load_val = 9'(lv); inc = i; dec = d; step = 4'(s);
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        arstn = 1'b0;
        model_reset();
        #100;
        checks++; if (a_out !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", a_out); end
        checks++; if ({a_ovf, a_udf, a_os, a_us} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {a_ovf, a_udf, a_os, a_us}); end
        arstn = 1'b1;
        tick();
        checks++; if (a_out !== 8'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", a_out); end
        set_in(0, 0, 0, 1, 0, 1);
        tick();
        checks++; if (a_out !== 8'd1) begin errors++; $display("FAIL first_inc: got %0d want 1", a_out); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL first_inc_ovf: got %b want 0", a_ovf); end
    endtask

    task automatic test_wrap();
        set_in(0, 1, 8, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 5);
        tick();
        checks++; if (b_out !== 8'd3) begin errors++; $display("FAIL wrap_out: got %0d want 3", b_out); end
        checks++; if (b_ovf !== 1'b1 || b_os !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got ovf=%b sticky=%b want 1 1", b_ovf, b_os); end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (b_ovf !== 1'b0 || b_os !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got ovf=%b sticky=%b want 0 1", b_ovf, b_os); end
    endtask

    task automatic test_underflow();
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 3);
        tick();
        checks++; if (b_out !== 8'd7 || b_udf !== 1'b1 || b_ovf !== 1'b0) begin errors++; $display("FAIL udf_wrap: got out=%0d udf=%b ovf=%b want 7 1 0", b_out, b_udf, b_ovf); end
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        checks++; if (b_out !== 8'd0 || b_os !== 1'b0 || b_us !== 1'b0) begin errors++; $display("FAIL clr: got out=%0d os=%b us=%b want 0 0 0", b_out, b_os, b_us); end
    endtask

    task automatic test_saturate();
        set_in(0, 1, 250, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 10);
        tick();
        checks++; if (c_out !== 8'd255 || c_ovf !== 1'b1) begin errors++; $display("FAIL sat_clamp: got out=%0d ovf=%b want 255 1", c_out, c_ovf); end
        checks++; if (a_out !== 8'd4 || a_ovf !== 1'b1) begin errors++; $display("FAIL wrap8: got out=%0d ovf=%b want 4 1", a_out, a_ovf); end
        tick();
        checks++; if (c_out !== 8'd255 || c_ovf !== 1'b1) begin errors++; $display("FAIL sat_again: got out=%0d ovf=%b want 255 1", c_out, c_ovf); end
    endtask

    task automatic test_simultaneous();
        set_in(1, 1, 77, 1, 0, 3);
        tick();
        checks++; if (a_out !== 8'd0 || d_out !== 9'd0) begin errors++; $display("FAIL clr_prio: got a=%0d d=%0d want 0 0", a_out, d_out); end
        set_in(0, 1, 300, 1, 0, 3);
        tick();
        checks++; if (d_out !== 9'd200) begin errors++; $display("FAIL load_clamp: got %0d want 200", d_out); end
        set_in(0, 0, 0, 1, 1, 7);
        tick();
        checks++; if (d_out !== 9'd200 || d_ovf !== 1'b0 || d_udf !== 1'b0) begin errors++; $display("FAIL inc_dec_hold: got out=%0d ovf=%b udf=%b want 200 0 0", d_out, d_ovf, d_udf); end
    endtask

    task automatic test_thresh();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0, 1);
        repeat (4) tick();
        checks++; if (b_out !== 8'd4 || b_th !== 1'b0) begin errors++; $display("FAIL thresh_below: got out=%0d hit=%b want 4 0", b_out, b_th); end
        tick();
        checks++; if (b_out !== 8'd5 || b_th !== 1'b1) begin errors++; $display("FAIL thresh_hit: got out=%0d hit=%b want 5 1", b_out, b_th); end
        set_in(0, 0, 0, 0, 0, 0);
        #3 arstn = 1'b0;
        model_reset();
        #1;
        checks++; if (b_out !== 8'd0 || b_th !== 1'b0) begin errors++; $display("FAIL async_reset: got out=%0d hit=%b want 0 0", b_out, b_th); end
        #2 arstn = 1'b1;
    endtask

    task automatic test_random();
        int o[4];
        bit f[4][5];
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 511),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
            tick();
            o = '{int'(a_out), int'(b_out), int'(c_out), int'(d_out)};
            f = '{'{a_ovf, a_udf, a_os, a_us, a_th}, '{b_ovf, b_udf, b_os, b_us, b_th},
                  '{c_ovf, c_udf, c_os, c_us, c_th}, '{d_ovf, d_udf, d_os, d_us, d_th}};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (o[i] != m_out[i]) begin errors++; $display("FAIL rand_out[%0d] cyc %0d: got %0d want %0d", i, n, o[i], m_out[i]); end
                checks++;
                if (f[i] != '{m_ovf[i], m_udf[i], m_os[i], m_us[i], m_out[i] >= TH[i]})
                    begin errors++; $display("FAIL rand_flags[%0d] cyc %0d: got ovf=%b udf=%b os=%b us=%b th=%b want %b %b %b %b %b",
                        i, n, f[i][0], f[i][1], f[i][2], f[i][3], f[i][4],
                        m_ovf[i], m_udf[i], m_os[i], m_us[i], m_out[i] >= TH[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_underflow();
        test_saturate();
        test_simultaneous();
        test_thresh();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
